sort_job_scheduler: RTL and testbench

- Shares one Sorter instance among NREQ requesters; each job loads ELEMENT_NUM words and returns ELEMENT_NUM sorted words.
- Round-robin arbitration, per-job sorter reset sequencing, LOAD streaming, result routing tagged with requester id, and a RUN watchdog.
- Sits between the requester subsystems and the Sorter.
- Sorter contract relied on: load counter starts on the first clk after its reset deasserts; outputs stream with SM_valid; done is sticky until reset.

---
 rtl/sort_job_scheduler_pkg.sv | 8 +
 rtl/sort_job_scheduler_rr_arbiter.sv | 18 +
 rtl/sort_job_scheduler.sv | 123 ++++++++++++
 tb/tb_sort_job_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_job_scheduler_pkg.sv
// sort_job_scheduler_pkg: shared sorter geometry, scheduler watchdog default and FSM states
package sort_job_scheduler_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ELEMENT_NUM = 8;
  localparam int LOG2_ELEMENT_NUM = 3;
  localparam int TIMEOUT_CYC = 1024;
  typedef enum logic [2:0] {IDLE, RST, LOAD, RUN, DONE, ABORT} state_t;
endpackage

// File: rtl/sort_job_scheduler_rr_arbiter.sv
// sort_job_scheduler_rr_arbiter: combinational round-robin pick, first request at or after ptr_i
module sort_job_scheduler_rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);
  // scan farthest-first so the request closest to the pointer is the last writer
  always_comb begin
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) gnt_o = N'(1) << ((int'(ptr_i) + k) % N);
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/sort_job_scheduler.sv
// sort_job_scheduler: shares one Sorter among NREQ requesters with RR arbitration and a RUN watchdog
module sort_job_scheduler
  import sort_job_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATA_WIDTH = sort_job_scheduler_pkg::DATA_WIDTH,
  parameter int ELEMENT_NUM = sort_job_scheduler_pkg::ELEMENT_NUM,
  parameter int LOG2_ELEMENT_NUM = sort_job_scheduler_pkg::LOG2_ELEMENT_NUM,
  parameter int TIMEOUT_CYC = sort_job_scheduler_pkg::TIMEOUT_CYC,
  localparam int IW = $clog2(NREQ),
  localparam int WW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]              gnt_o,
  output logic [NREQ-1:0]              pop_o,
  output logic                         out_valid_o,
  output logic [LOG2_ELEMENT_NUM-1:0]  out_addr_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [IW-1:0]                out_id_o,
  output logic                         job_done_o,
  output logic                         job_err_o,
  output logic                         srt_rst_o,
  output logic                         srt_um_valid_o,
  output logic [DATA_WIDTH-1:0]        srt_um_data_o,
  input  logic                         srt_sm_valid_i,
  input  logic [LOG2_ELEMENT_NUM-1:0]  srt_sm_addr_i,
  input  logic [DATA_WIDTH-1:0]        srt_sm_data_i,
  input  logic                         srt_done_i
);
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, arb_idx;
  logic [NREQ-1:0] gnt_q, gnt_d, arb_gnt;
  logic arb_valid;
  logic [LOG2_ELEMENT_NUM-1:0] load_cnt_q, load_cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic srt_rst_q, srt_rst_d, out_valid_q, out_valid_d;
  logic [LOG2_ELEMENT_NUM-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  sort_job_scheduler_rr_arbiter #(.N(NREQ)) u_arb (
    .req_i  (req_i),
    .ptr_i  (rr_q),
    .gnt_o  (arb_gnt),
    .valid_o(arb_valid)
  );

  // one-hot winner to requester index
  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < NREQ; k++)
      if (arb_gnt[k]) arb_idx = IW'(k);
  end

  // job sequencing; sorter reset drops only while the next state is LOAD or RUN
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    load_cnt_d = (state_q == LOAD) ? load_cnt_q + 1'b1 : '0;
    wd_d = (state_q == RUN) ? wd_q + 1'b1 : '0;
    out_valid_d = (state_q == RUN) && srt_sm_valid_i && !srt_done_i;
    out_addr_d = out_valid_d ? srt_sm_addr_i : out_addr_q;
    out_data_d = out_valid_d ? srt_sm_data_i : out_data_q;
    case (state_q)
      IDLE: if (arb_valid) begin
        state_d = RST;
        owner_d = arb_idx;
      end
      RST: state_d = LOAD;
      LOAD: if (load_cnt_q == LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1)) state_d = RUN;
      RUN: state_d = srt_done_i ? DONE : (wd_q == WW'(TIMEOUT_CYC - 1)) ? ABORT : RUN;
      DONE, ABORT: begin
        state_d = IDLE;
        rr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    srt_rst_d = !(state_d == LOAD || state_d == RUN);
    gnt_d = (state_d == RST) ? arb_gnt : (srt_rst_d ? '0 : gnt_q);
  end

  // state and datapath registers, cleared asynchronously with the sorter held in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      gnt_q <= '0;
      load_cnt_q <= '0;
      wd_q <= '0;
      srt_rst_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      load_cnt_q <= load_cnt_d;
      wd_q <= wd_d;
      srt_rst_q <= srt_rst_d;
      out_valid_q <= out_valid_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign gnt_o = gnt_q;
  assign pop_o = (state_q == LOAD) ? gnt_q : '0;
  assign srt_um_valid_o = (state_q == LOAD);
  assign srt_um_data_o = (state_q == LOAD) ? req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign srt_rst_o = srt_rst_q;
  assign out_valid_o = out_valid_q;
  assign out_addr_o = out_addr_q;
  assign out_data_o = out_data_q;
  assign out_id_o = owner_q;
  assign job_done_o = (state_q == DONE);
  assign job_err_o = (state_q == ABORT);
endmodule

// File: tb/tb_sort_job_scheduler.sv
// tb_sort_job_scheduler: directed jobs with a Sorter stand-in and a queue-based scoreboard
module tb_sort_job_scheduler;
  localparam int N = 4, DW = 8, EN = 8, TO = 64;
  typedef struct packed {logic [1:0] id; logic [2:0] addr; logic [7:0] data;} res_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, gnt, pop;
  logic [N*DW-1:0] req_data;
  logic out_valid, job_done, job_err, srt_rst, um_valid;
  logic [2:0] out_addr, sm_addr;
  logic [7:0] out_data, um_data, sm_data;
  logic [1:0] out_id;
  logic sm_valid, sm_done, withhold = 1'b0;

  int errors = 0, checks = 0;
  res_t rq[$];
  logic [1:0] gq[$];
  logic eq[$];

  sort_job_scheduler #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .req_data_i(req_data),
    .gnt_o(gnt), .pop_o(pop), .out_valid_o(out_valid), .out_addr_o(out_addr),
    .out_data_o(out_data), .out_id_o(out_id), .job_done_o(job_done), .job_err_o(job_err),
    .srt_rst_o(srt_rst), .srt_um_valid_o(um_valid), .srt_um_data_o(um_data),
    .srt_sm_valid_i(sm_valid), .srt_sm_addr_i(sm_addr), .srt_sm_data_i(sm_data),
    .srt_done_i(sm_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // requesters: FWFT word lists, head advances on pop, rewinds while not granted
  logic [7:0] words[N][EN];
  int idx[N];
  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = (idx[i] < EN) ? words[i][idx[i]] : 8'h00;
  end
  always @(posedge clk)
    for (int i = 0; i < N; i++) idx[i] <= !gnt[i] ? 0 : pop[i] ? idx[i] + 1 : idx[i];

  // Sorter stand-in: load 8 words, stream ascending by rank, then hold addr 7 with sticky done
  logic [7:0] mbuf[EN], sorted[EN];
  logic [2:0] rank[EN];
  int lcnt, ocnt, phase;
  always_comb
    for (int j = 0; j < EN; j++) begin
      rank[j] = 3'd0;
      for (int k = 0; k < EN; k++)
        if (mbuf[k] < mbuf[j] || (mbuf[k] == mbuf[j] && k < j)) rank[j] = rank[j] + 3'd1;
    end
  always_comb begin
    for (int r = 0; r < EN; r++) sorted[r] = 8'h00;
    for (int j = 0; j < EN; j++) sorted[rank[j]] = mbuf[j];
  end
  always @(posedge clk) begin
    if (srt_rst) begin
      lcnt <= 0; ocnt <= 0; phase <= 0; sm_valid <= 1'b0; sm_done <= 1'b0; sm_addr <= '0; sm_data <= '0;
    end else case (phase)
      0: if (um_valid) begin
        mbuf[lcnt] <= um_data;
        lcnt <= lcnt + 1;
        if (lcnt == EN - 1) phase <= 1;
      end
      1: phase <= 2;
      2: begin
        sm_valid <= 1'b1;
        sm_addr <= 3'(ocnt);
        sm_data <= sorted[ocnt];
        ocnt <= ocnt + 1;
        if (ocnt == EN - 1) phase <= 3;
      end
      3: if (withhold) sm_valid <= 1'b0; else sm_done <= 1'b1;
      default: ;
    endcase
  end

  // monitor: invariants, grant order, result scoreboard, job-end bookkeeping
  int cyc = 0, last_pop = 0, last_end = 0, gap = 0, pop_cnt = 0, res_cnt = 0;
  logic [3:0] prev_gnt = '0;
  res_t exp_r;
  logic [1:0] exp_g;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_gnt = '0; pop_cnt = 0; res_cnt = 0;
    end else begin
      chk("gnt_onehot", int'($onehot0(gnt)), 1);
      chk("pop_subset_gnt", int'(pop & ~gnt), 0);
      chk("done_err_exclusive", int'(job_done && job_err), 0);
      if (gnt != 0 && prev_gnt == 0) begin
        if (gq.size() == 0) chk("gnt_queue_nonempty", gq.size(), 1);
        else begin
          exp_g = gq.pop_front();
          chk("gnt_owner", int'(gnt), 1 << exp_g);
        end
        gap = cyc - last_end; pop_cnt = 0; res_cnt = 0;
      end
      if (out_valid) begin
        res_cnt++;
        if (rq.size() == 0) chk("result_queue_nonempty", rq.size(), 1);
        else begin
          exp_r = rq.pop_front();
          chk("res_id", int'(out_id), int'(exp_r.id));
          chk("res_addr", int'(out_addr), int'(exp_r.addr));
          chk("res_data", int'(out_data), int'(exp_r.data));
        end
      end
      if (|pop) begin pop_cnt++; last_pop = cyc; end
      if (job_done || job_err) begin
        if (eq.size() == 0) chk("end_queue_nonempty", eq.size(), 1);
        else chk("end_is_err", int'(job_err), int'(eq.pop_front()));
        chk("pop_cycles", pop_cnt, EN);
        chk("results_per_job", res_cnt, EN);
        chk("srt_rst_at_end", int'(srt_rst), 1);
        chk("gnt_clear_at_end", int'(gnt), 0);
        if (job_err) chk("watchdog_latency", cyc - last_pop, TO + 1);
        last_end = cyc;
      end
      prev_gnt = gnt;
    end
  end

  task automatic set_words(input int i, input logic [63:0] v);
    for (int k = 0; k < EN; k++) words[i][k] = v[k*8 +: 8];
  endtask
  task automatic push_job(input logic [1:0] id, input logic [63:0] e, input logic err);
    res_t r;
    for (int a = 0; a < EN; a++) begin
      r.id = id; r.addr = 3'(a); r.data = e[a*8 +: 8];
      rq.push_back(r);
    end
    gq.push_back(id);
    eq.push_back(err);
  endtask
  task automatic wait_gnt();
    logic [3:0] p = gnt;
    bit ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (gnt != 0 && p == 0) ok = 1;
      p = gnt;
    end
    chk("gnt_within_bound", int'(ok), 1);
  endtask
  task automatic wait_end();
    bit ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (job_done || job_err) ok = 1;
    end
    chk("end_within_bound", int'(ok), 1);
  endtask

  localparam logic [63:0] S0 = 64'h0706050403020100, S1 = 64'h0908070605040302;
  localparam logic [63:0] S2 = 64'h0807060504030201, S3 = 64'hFFC8643211110100;

  initial begin
    int n;
    bit seen;
    set_words(0, 64'h0402060001070305);
    set_words(1, 64'h0203040506070809);
    set_words(2, 64'h0702050403060108);
    set_words(3, 64'h320164FF001111C8);
    repeat (3) @(negedge clk);
    chk("rst_srt_rst", int'(srt_rst), 1);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_pop", int'(pop), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_job_done", int'(job_done), 0);
    chk("rst_job_err", int'(job_err), 0);
    chk("rst_um_valid", int'(um_valid), 0);
    chk("rst_out_id", int'(out_id), 0);
    rst = 1'b0;
    @(negedge clk);
    push_job(0, S0, 0);
    req = 4'b0001;
    wait_gnt();
    req = '0;
    wait_end();
    push_job(1, S1, 0); push_job(3, S3, 0); push_job(0, S0, 0); push_job(1, S1, 0);
    req = 4'b1011;
    wait_gnt();
    for (int g = 1; g < 4; g++) begin
      wait_gnt();
      chk("rr_gap", gap, 2);
    end
    req = '0;
    wait_end();
    push_job(2, S2, 1); push_job(1, S1, 0);
    withhold = 1'b1;
    req = 4'b0110;
    wait_gnt();
    wait_end();
    withhold = 1'b0;
    wait_gnt();
    req = '0;
    wait_end();
    gq.push_back(0);
    req = 4'b0001;
    wait_gnt();
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(negedge clk);
      if (pop[0]) n++;
    end
    chk("pops_before_reset", n, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_pop", int'(pop), 0);
    chk("arst_srt_rst", int'(srt_rst), 1);
    chk("arst_um_valid", int'(um_valid), 0);
    chk("arst_job_done", int'(job_done), 0);
    chk("arst_job_err", int'(job_err), 0);
    repeat (2) @(negedge clk);
    push_job(0, S0, 0);
    rst = 1'b0;
    wait_gnt();
    req = '0;
    wait_end();
    push_job(2, S2, 0);
    req = 4'b0100;
    wait_gnt();
    seen = 0;
    for (int c = 0; c < 50 && !(seen && pop == 0); c++) begin
      @(negedge clk);
      if (pop != 0) seen = 1;
    end
    req = '0;
    wait_end();
    repeat (5) @(negedge clk);
    chk("results_drained", rq.size(), 0);
    chk("grants_drained", gq.size(), 0);
    chk("ends_drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
